instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/fetch_watchdog.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state type, opcode constants,
// instruction field bit positions and small decode/align helpers.
package cpu_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(
    input logic [31:0] ir
  );
    instr_fields_t f;
    f.opcode = ir[OPC_MSB:OPC_LSB];
    f.rs     = ir[RS_MSB:RS_LSB];
    f.rt     = ir[RT_MSB:RT_LSB];
    f.rd     = ir[RD_MSB:RD_LSB];
    f.funct  = ir[FN_MSB:FN_LSB];
    f.imm16  = ir[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  // Instruction memory is word addressed; byte offset bits are dropped.
  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch timeout counter; exists only when FETCH_TIMEOUT_EN is defined.
// Ports: clk, rst (async high), run_i (FSM in FETCH), ack_i (memory
// ack), expired_o (high in the TIMEOUT_CYCLES-th FETCH cycle w/o ack).
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = run_i && (cnt_q == LAST);

  // Counter restarts whenever the FSM leaves FETCH, so each
  // request gets a fresh budget.
  always_comb begin
    cnt_d = '0;
    if (run_i && !ack_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/instruction_fetch_unit.sv
// Multicycle instruction fetch: PC, IR, IDLE/FETCH handshake FSM and
// combinational IR field decode.
// Ports: clk, rst (async high); fetch_start, pc_load, pc_next from
// control; imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
// fetch_done pulse; Instr and decoded fields Opcode/Rs/Rt/Rd/Funct/
// Imm16/ZeroExtendCTL; pc, pc_plus4; fetch_err sticky timeout flag.
// Option: FETCH_TIMEOUT_EN adds a watchdog that aborts stalled fetches.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [5:0]  LUI_OPCODE     = OPC_LUI,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_done,
  output logic [31:0] Instr,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [5:0]  Funct,
  output logic [15:0] Imm16,
  output logic        ZeroExtendCTL,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic [31:0]   instr_q;
  logic [31:0]   instr_d;
  logic          done_q;
  logic          done_d;
  logic          timeout;
  instr_fields_t fields;

`ifdef FETCH_TIMEOUT_EN
  logic err_q;
  logic err_d;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == ST_FETCH),
    .ack_i    (imem_ack),
    .expired_o(timeout)
  );

  // Set on timeout, cleared when the next fetch is accepted.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && fetch_start) begin
      err_d = 1'b0;
    end else if (state_q == ST_FETCH && !imem_ack && timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    done_d    = 1'b0;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      ST_IDLE: begin
        // A same-cycle load is visible to the fetch because the
        // request is issued from the registered PC next cycle.
        if (pc_load) begin
          pc_d = word_align(pc_next);
        end
        if (fetch_start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = pc_plus4;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      done_q  <= done_d;
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + PC_STEP;
  assign Instr      = instr_q;
  assign fetch_done = done_q;

  assign fields        = decode_fields(instr_q);
  assign Opcode        = fields.opcode;
  assign Rs            = fields.rs;
  assign Rt            = fields.rt;
  assign Rd            = fields.rd;
  assign Funct         = fields.funct;
  assign Imm16         = fields.imm16;
  assign ZeroExtendCTL = (fields.opcode == LUI_OPCODE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table of
// fetches, scoreboard on fetch_done, plus reset/timeout sequences.
module tb_instruction_fetch_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        fetch_done;
  logic [31:0] Instr;
  logic [5:0]  Opcode;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [5:0]  Funct;
  logic [15:0] Imm16;
  logic        ZeroExtendCTL;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  instruction_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .LUI_OPCODE    (6'b001111),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_start  (fetch_start),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .fetch_done   (fetch_done),
    .Instr        (Instr),
    .Opcode       (Opcode),
    .Rs           (Rs),
    .Rt           (Rt),
    .Rd           (Rd),
    .Funct        (Funct),
    .Imm16        (Imm16),
    .ZeroExtendCTL(ZeroExtendCTL),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [31:0] pc_next;
    int          delay;
    logic        disturb;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        zext;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        zext;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  vec_t v_tail;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_push  = 0;
  int   n_done  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && fetch_done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got pulse expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", Instr, e.instr);
        check("sb_pc", pc, e.pc);
        check("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
        check("sb_opcode", 32'(Opcode), 32'(e.opc));
        check("sb_rs", 32'(Rs), 32'(e.rs));
        check("sb_rt", 32'(Rt), 32'(e.rt));
        check("sb_rd", 32'(Rd), 32'(e.rd));
        check("sb_funct", 32'(Funct), 32'(e.funct));
        check("sb_imm16", 32'(Imm16), 32'(e.imm));
        check("sb_zext", 32'(ZeroExtendCTL), 32'(e.zext));
      end
    end
  end

  task automatic do_fetch(input vec_t v);
    exp_t e;
    @(negedge clk);
    fetch_start = 1'b1;
    pc_load     = v.load;
    pc_next     = v.pc_next;
    e = '{v.rdata, v.exp_pc, v.opc, v.rs, v.rt, v.rd,
          v.funct, v.imm, v.zext};
    sb.push_back(e);
    n_push++;
    @(negedge clk);
    check("err_clear", 32'(fetch_err), 32'h0);
    for (int i = 0; i < v.delay; i++) begin
      check("req_high", 32'(imem_req), 32'h1);
      check("addr", imem_addr, v.exp_addr);
      imem_ack    = (i == v.delay - 1);
      imem_rdata  = (i == v.delay - 1) ? v.rdata : 32'hDEAD_BEEF;
      pc_load     = v.disturb && (i != v.delay - 1);
      fetch_start = v.disturb && (i != v.delay - 1);
      pc_next     = 32'h0000_0500;
      @(negedge clk);
    end
    imem_ack    = 1'b0;
    pc_load     = 1'b0;
    fetch_start = 1'b0;
    check("done_pulse", 32'(fetch_done), 32'h1);
    check("req_low", 32'(imem_req), 32'h0);
    @(negedge clk);
    check("done_single", 32'(fetch_done), 32'h0);
    check("req_idle", 32'(imem_req), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim still running");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pre_instr;
    logic [31:0] pre_pc;
    int          cnt;

    vecs[0] = '{1'b0, 32'h0, 1, 1'b0, 32'h3C01_1234, 32'h0000_0000,
                32'h0000_0004, 6'h0F, 5'd0, 5'd1, 5'd2, 6'h34,
                16'h1234, 1'b1};
    vecs[1] = '{1'b0, 32'h0, 5, 1'b1, 32'h3421_00FF, 32'h0000_0004,
                32'h0000_0008, 6'h0D, 5'd1, 5'd1, 5'd0, 6'h3F,
                16'h00FF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0103, 1, 1'b0, 32'h8C22_0010,
                32'h0000_0100, 32'h0000_0104, 6'h23, 5'd1, 5'd2,
                5'd0, 6'h10, 16'h0010, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 2, 1'b0, 32'h3C0A_FFFF,
                32'hFFFF_FFFC, 32'h0000_0000, 6'h0F, 5'd0, 5'd10,
                5'd31, 6'h3F, 16'hFFFF, 1'b1};
    vecs[4] = '{1'b0, 32'h0, 3, 1'b0, 32'h0043_2020, 32'h0000_0000,
                32'h0000_0004, 6'h00, 5'd2, 5'd3, 5'd4, 6'h20,
                16'h2020, 1'b0};
    v_tail  = '{1'b0, 32'h0, 1, 1'b0, 32'h2008_0005, 32'h0000_0004,
                32'h0000_0008, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05,
                16'h0005, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_instr", Instr, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_done", 32'(fetch_done), 32'h0);
    check("rst_err", 32'(fetch_err), 32'h0);
    check("rst_zext", 32'(ZeroExtendCTL), 32'h0);

    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    check("idle_ack_instr", Instr, 32'h0);
    check("idle_ack_pc", pc, 32'h0);
    check("idle_ack_req", 32'(imem_req), 32'h0);

    for (int k = 0; k < 5; k++) begin
      do_fetch(vecs[k]);
    end

`ifdef FETCH_TIMEOUT_EN
    pre_instr = Instr;
    pre_pc    = pc;
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    cnt = 0;
    while (imem_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 32'(cnt), 32'(TMO));
    check("tmo_err", 32'(fetch_err), 32'h1);
    check("tmo_instr", Instr, pre_instr);
    check("tmo_pc", pc, pre_pc);
    do_fetch(v_tail);
`else
    cnt = 0;
    pre_instr = 32'h0;
    pre_pc    = 32'h0;
    v_tail.delay = TMO + 5;
    do_fetch(v_tail);
    check("no_tmo_err", 32'(fetch_err) + 32'(cnt), 32'h0);
`endif

    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    check("pre_rst_req", 32'(imem_req), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_req", 32'(imem_req), 32'h0);
    check("rstmid_instr", Instr, 32'h0);
    check("rstmid_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("post_rst_req", 32'(imem_req), 32'h0);
    check("post_rst_done", 32'(fetch_done), 32'h0);
    @(negedge clk);
    check("post_rst_done2", 32'(fetch_done), 32'h0);
    check("post_rst_instr", Instr, 32'h0);
    check("post_rst_pc", pc, 32'h0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    check("done_count", 32'(n_done), 32'(n_push));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
